// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared constants and types for the store buffer and its neighbours in the
// commit path. SB_WIDTH is the log2 entry count of the store buffer;
// COMMIT_RING_WIDTH sizes the commit ring that retires stores into it.
// sb_entry_t is the {addr, data} payload of one buffered store at the
// default address/data widths.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int COMMIT_RING_WIDTH = 4;
  localparam int SB_WIDTH          = 3;
  localparam int SB_ADDR_WIDTH     = 20;
  localparam int SB_DATA_WIDTH     = 32;

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_forward.sv
// -----------------------------------------------------------------------------
// store_buffer_forward
// Combinational store-to-load forwarding search. Scans the live entries from
// head (oldest) towards tail (youngest); a later match overrides an earlier
// one, so the reported data comes from the youngest matching store.
//
// Ports:
//   entry_addr / entry_data : entry storage arrays, indexed by pointer LSBs
//   head, tail              : SB_WIDTH+1 bit pointers bounding the live range
//   load_addr               : lookup address
//   hit                     : some live entry holds load_addr
//   data                    : data of the youngest matching entry (0 on miss)
// -----------------------------------------------------------------------------
module store_buffer_forward #(
  parameter int SB_WIDTH   = store_buffer_pkg::SB_WIDTH,
  parameter int ADDR_WIDTH = store_buffer_pkg::SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = store_buffer_pkg::SB_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] entry_addr [2**SB_WIDTH],
  input  logic [DATA_WIDTH-1:0] entry_data [2**SB_WIDTH],
  input  logic [SB_WIDTH:0]     head,
  input  logic [SB_WIDTH:0]     tail,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);
  import store_buffer_pkg::*;

  localparam int DEPTH = 2 ** SB_WIDTH;

  logic [SB_WIDTH:0]   occupancy_s;
  logic [SB_WIDTH-1:0] idx_s;
  logic                match_s;

  // Oldest-to-youngest scan; the last match seen wins.
  always_comb begin
    occupancy_s = tail - head;
    hit         = 1'b0;
    data        = '0;
    idx_s       = '0;
    match_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s   = head[SB_WIDTH-1:0] + SB_WIDTH'(i);
      match_s = ((SB_WIDTH+1)'(i) < occupancy_s) && (entry_addr[idx_s] == load_addr);
      hit     = hit | match_s;
      data    = match_s ? entry_data[idx_s] : data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Circular store buffer between the load/store unit and data memory. Stores
// enter speculatively at tail, become committed when the commit ring retires
// them (commit pointer), and drain from head to memory. A flush discards the
// uncommitted region by pulling tail back to the commit pointer.
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   sw_valid/sw_ready/sw_addr/sw_data: speculative enqueue handshake
//   commit_sw_valid/commit_sw_ready  : commit of the oldest uncommitted store
//   flush                            : drop all uncommitted stores
//   mem_we/mem_ready/mem_addr/mem_data: drain write of the head entry
//   load_addr/load_hit/load_data     : store-to-load forwarding lookup
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int SB_WIDTH   = store_buffer_pkg::SB_WIDTH,
  parameter int ADDR_WIDTH = store_buffer_pkg::SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = store_buffer_pkg::SB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_valid,
  output logic                  sw_ready,
  input  logic [ADDR_WIDTH-1:0] sw_addr,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  commit_sw_valid,
  output logic                  commit_sw_ready,
  input  logic                  flush,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  load_hit,
  output logic [DATA_WIDTH-1:0] load_data
);
  import store_buffer_pkg::*;

  localparam int DEPTH = 2 ** SB_WIDTH;

  typedef logic [SB_WIDTH:0] ptr_t;

  // One extra pointer bit distinguishes full from empty.
  localparam ptr_t FULL_COUNT = ptr_t'(DEPTH);
  localparam ptr_t PTR_ZERO   = ptr_t'(0);
  localparam ptr_t PTR_ONE    = ptr_t'(1);

  ptr_t head_r;
  ptr_t commit_r;
  ptr_t tail_r;
  ptr_t head_nxt_s;
  ptr_t commit_nxt_s;
  ptr_t tail_nxt_s;
  ptr_t occupancy_s;
  ptr_t committed_s;
  ptr_t pending_s;

  logic enq_s;
  logic commit_fire_s;
  logic drain_s;

  logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];

  // Handshake readiness comes from registered pointers only, so sw_ready
  // never depends on mem_ready and a new store is never committable in the
  // cycle it is enqueued.
  always_comb begin
    occupancy_s     = tail_r - head_r;
    committed_s     = commit_r - head_r;
    pending_s       = tail_r - commit_r;
    sw_ready        = (occupancy_s != FULL_COUNT);
    commit_sw_ready = (pending_s != PTR_ZERO);
    mem_we          = (committed_s != PTR_ZERO);
    enq_s           = sw_valid && sw_ready && !flush;
    commit_fire_s   = commit_sw_valid && commit_sw_ready;
    drain_s         = mem_we && mem_ready;
  end

  // Next pointer values; flush rewinds tail to the post-commit pointer so a
  // same-cycle commit survives and a same-cycle enqueue is dropped.
  always_comb begin
    head_nxt_s   = drain_s ? (head_r + PTR_ONE) : head_r;
    commit_nxt_s = commit_fire_s ? (commit_r + PTR_ONE) : commit_r;
    if (flush) begin
      tail_nxt_s = commit_nxt_s;
    end else if (enq_s) begin
      tail_nxt_s = tail_r + PTR_ONE;
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Pointer registers; reset empties the buffer, committed entries included.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r   <= PTR_ZERO;
      commit_r <= PTR_ZERO;
      tail_r   <= PTR_ZERO;
    end else begin
      head_r   <= head_nxt_s;
      commit_r <= commit_nxt_s;
      tail_r   <= tail_nxt_s;
    end
  end

  // Entry storage; the tail slot is never the head slot while not full, so
  // the entry being drained cannot be overwritten.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_r[tail_r[SB_WIDTH-1:0]] <= sw_addr;
      data_mem_r[tail_r[SB_WIDTH-1:0]] <= sw_data;
    end
  end

  // Drain port presents the head entry; it holds until head moves.
  always_comb begin
    mem_addr = addr_mem_r[head_r[SB_WIDTH-1:0]];
    mem_data = data_mem_r[head_r[SB_WIDTH-1:0]];
  end

  store_buffer_forward #(
    .SB_WIDTH   (SB_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_forward (
    .entry_addr (addr_mem_r),
    .entry_data (data_mem_r),
    .head       (head_r),
    .tail       (tail_r),
    .load_addr  (load_addr),
    .hit        (load_hit),
    .data       (load_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer. Stimulus tasks keep a small model: a
// queue of speculative stores and a queue of committed stores awaiting the
// memory drain. A separate monitor compares every drain write against the
// front of the committed queue.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_valid;
  logic          sw_ready;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic          commit_sw_valid;
  logic          commit_sw_ready;
  logic          flush;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] load_addr;
  logic          load_hit;
  logic [DW-1:0] load_data;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t spec_q[$];
  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_mode = 1'b0;

  store_buffer #(.SB_WIDTH(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_valid        (sw_valid),
    .sw_ready        (sw_ready),
    .sw_addr         (sw_addr),
    .sw_data         (sw_data),
    .commit_sw_valid (commit_sw_valid),
    .commit_sw_ready (commit_sw_ready),
    .flush           (flush),
    .mem_we          (mem_we),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .load_addr       (load_addr),
    .load_hit        (load_hit),
    .load_data       (load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drain monitor: any write while mem_we is high must match the oldest
  // committed store; it is consumed when mem_ready accepts it.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL drain_unexpected: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_data);
      end else begin
        if (mem_addr !== exp_q[0].a || mem_data !== exp_q[0].d) begin
          n_bad++;
          $display("FAIL drain_entry: got (0x%0h,0x%0h) expected (0x%0h,0x%0h)",
                   mem_addr, mem_data, exp_q[0].a, exp_q[0].d);
        end
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic c, input logic f, output logic acc);
    logic rdy;
    rdy = ((spec_q.size() + exp_q.size()) != 8);
    if (rand_mode) mem_ready = 1'($urandom_range(0, 1));
    sw_valid        = v;
    sw_addr         = a;
    sw_data         = d;
    commit_sw_valid = c;
    flush           = f;
    #1;
    chk("sw_ready", 32'(sw_ready), 32'(rdy));
    chk("commit_sw_ready", 32'(commit_sw_ready), 32'(spec_q.size() != 0));
    chk("mem_we", 32'(mem_we), 32'(exp_q.size() != 0));
    acc = 1'b0;
    if (c && spec_q.size() != 0) exp_q.push_back(spec_q.pop_front());
    if (f) begin
      spec_q.delete();
    end else if (v && rdy) begin
      spec_q.push_back({a, d});
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    sw_valid        = 1'b0;
    commit_sw_valid = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    cycle(1'b1, a, d, 1'b0, 1'b0, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic commit1();
    logic acc;
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic drain_all();
    logic acc;
    int   guard;
    guard = 0;
    while ((spec_q.size() != 0 || exp_q.size() != 0) && guard < 200) begin
      cycle(1'b0, '0, '0, spec_q.size() != 0, 1'b0, acc);
      guard++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", spec_q.size() + exp_q.size());
    end
  endtask

  task automatic check_load(input string nm, input logic [AW-1:0] a,
                            input logic h, input logic [DW-1:0] d);
    load_addr = a;
    #1;
    chk({nm, "_hit"}, 32'(load_hit), 32'(h));
    if (h) chk({nm, "_data"}, load_data, d);
  endtask

  task automatic reset_checks(input logic [AW-1:0] stale_addr);
    chk("rst_sw_ready", 32'(sw_ready), 32'd1);
    chk("rst_commit_ready", 32'(commit_sw_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    check_load("rst_load", stale_addr, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   i;
    int   guard;
    reset = 1'b1; sw_valid = 1'b0; sw_addr = '0; sw_data = '0;
    commit_sw_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0; load_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_checks(20'h00000);

    // Two stores committed and drained back to back.
    mem_ready = 1'b1;
    enq(20'h10, 32'd1);
    enq(20'h20, 32'd2);
    commit1();
    commit1();
    idle(3);

    // Fill all 8 entries; 9th store held until one entry drains.
    mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) enq(AW'(32'h100 + k), DW'(k + 16));
    cycle(1'b1, 20'h200, 32'hAA, 1'b1, 1'b0, acc);
    mem_ready = 1'b1;
    cycle(1'b1, 20'h200, 32'hAA, 1'b0, 1'b0, acc);
    cycle(1'b1, 20'h200, 32'hAA, 1'b0, 1'b0, acc);
    drain_all();

    // Flush after one commit: exactly one drain write.
    enq(20'h60, 32'd6);
    enq(20'h64, 32'd7);
    enq(20'h68, 32'd8);
    commit1();
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(4);

    // Flush coinciding with a commit and an enqueue.
    enq(20'h40, 32'd3);
    enq(20'h44, 32'd4);
    cycle(1'b1, 20'h48, 32'd7, 1'b1, 1'b1, acc);
    idle(4);

    // Forwarding: youngest match wins; in-flight enqueue is invisible.
    mem_ready = 1'b0;
    enq(20'h30, 32'd5);
    enq(20'h30, 32'd9);
    enq(20'h34, 32'd1);
    check_load("fwd_young", 20'h30, 1'b1, 32'd9);
    check_load("fwd_other", 20'h34, 1'b1, 32'd1);
    sw_valid = 1'b1; sw_addr = 20'h38; sw_data = 32'd2;
    check_load("fwd_inflight", 20'h38, 1'b0, '0);
    enq(20'h38, 32'd2);
    check_load("fwd_after_enq", 20'h38, 1'b1, 32'd2);
    commit1();
    check_load("fwd_committed", 20'h30, 1'b1, 32'd9);
    mem_ready = 1'b1;
    drain_all();
    check_load("fwd_drained", 20'h30, 1'b0, '0);

    // 20 stores through the buffer with random drain backpressure.
    rand_mode = 1'b1;
    i = 0;
    guard = 0;
    while (i < 20 && guard < 400) begin
      cycle(1'b1, AW'(32'h500 + i), DW'(i * 3 + 1), 1'b1, 1'b0, acc);
      if (acc) i++;
      guard++;
    end
    chk("wrap_enqueued", 32'(i), 32'd20);
    rand_mode = 1'b0;
    mem_ready = 1'b1;
    drain_all();

    // Reset in the middle of a stalled drain discards committed entries.
    mem_ready = 1'b0;
    enq(20'h70, 32'd11);
    enq(20'h74, 32'd12);
    commit1();
    commit1();
    reset = 1'b1;
    spec_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_checks(20'h70);
    mem_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
